fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Sequences the pre-IF program-counter selection and instruction-request handshake for the fetch pipeline. Arbitrates five next-PC sources: exception flush, return/refetch flush, branch mispredict, BTB-predicted taken, and sequential. A redirect that the instruction cache does not accept immediately is held in a pending register until it is accepted. Also owns the idle lock. Sits between the CSR/writeback flush logic, the decode-stage branch unit, the BTB and the icache request port.

## Interface
- No parameters; reset PC is fixed at 0x1c000000.
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- fetch_ready  in  1  IF stage can take a new request (fs_allowin)
- excp_flush  in  1  exception commit pulse
- excp_target  in  32  exception entry (eentry/tlbrentry, already selected)
- ertn_flush  in  1  ertn commit pulse
- era  in  32  return address
- refetch_flush, icacop_flush, idle_flush  in  1 each  commit pulses that resume at ws_pc+4
- ws_pc  in  32  writeback PC
- has_int  in  1  pending interrupt
- br_flush  in  1  decode-stage BTB mispredict pulse
- br_target  in  32  corrected target
- btb_valid  in  1  BTB lookup result valid (one cycle only)
- btb_taken  in  1  predicted taken
- btb_target  in  32  predicted target
- inst_addr_ok  in  1  icache accepted request
- inst_req  out  1  icache request valid
- inst_addr  out  32  request address (nextpc)
- inst_adef  out  1  inst_addr[1:0] != 0
- redirect_kill  out  1  invalidate IF-stage instruction this cycle
- pend_valid  out  1  redirect pending (status)
- idle_lock  out  1  fetch halted by idle

## Operation
- Source classes, highest first: EXC(3) = excp_flush; FL(2) = ertn, refetch, icacop or idle flush; BR(1) = br_flush; BTB = btb_taken held or live; SEQ = last_pc + 4.
- FL target: era when ertn_flush is asserted, else ws_pc + 4. All additions are 32-bit modulo; 0xfffffffc + 4 wraps to 0.
- Live event: the highest-class asserted flush or branch input this cycle.
- nextpc:
  - If a live event exists with class ≥ pend_cls, or no pending entry exists: the live event's target.
  - Else, if a pending entry exists: pend_target.
  - Else: BTB target if a taken prediction is live or held.
  - Else: SEQ.
- inst_req = resetn && !idle_lock && !idle_flush && (pend_valid || live event || fetch_ready).
- Accept = inst_req && inst_addr_ok. On accept: last_pc <= inst_addr, pending cleared, BTB hold cleared.
- Live event without accept: pending <= {class, target}.
- Live event while pending: overwrites pending only if its class ≥ pend_cls; a lower class is dropped.
- BTB hold: btb_valid && !accept captures {btb_taken, btb_target}. Cleared on accept or on any live event.
- redirect_kill = any live event (EXC, FL or BR), combinational.
- idle_lock: set on idle_flush && !has_int. Cleared on has_int; has_int wins when both are asserted. While locked, inst_req = 0 and pending is retained.
- idle_flush with has_int asserted: no lock. The ws_pc+4 redirect goes pending and issues next cycle.

## Timing
- nextpc, inst_req, inst_adef and redirect_kill are combinational on the current inputs and state. There are no registered outputs except pend_valid and idle_lock.
- Redirect-to-request latency is 0 cycles when the event's class ≥ any pending class. An event that arrives while locked issues in the first cycle after has_int clears the lock.
- Reset values (asynchronous, on resetn low):
  - last_pc = 0x1bfffffc
  - pend_valid = 0, pend_cls = 0
  - BTB hold = 0
  - idle_lock = 0
- While resetn is low, inst_req = 0 and redirect_kill = 0.
- First request after reset release: inst_addr = 0x1c000000, provided fetch_ready = 1.
- Reset asserted mid-pending discards the pending redirect.
- A simultaneous live event and accept captures nothing into pending; last_pc takes the event target.

## Test plan
- Reset release, fetch_ready = 1, inst_addr_ok = 1 each cycle -> inst_addr = 0x1c000000, 0x1c000004, 0x1c000008; redirect_kill = 0.
- br_flush with br_target = 0x1c000100 while inst_addr_ok = 0 for 3 cycles -> pend_valid = 1 and inst_addr = 0x1c000100 held each cycle; on accept pend_valid -> 0 and the next address is 0x1c000104.
- Pending BR 0x1c000100, then excp_flush with excp_target = 0x1c008000 while not accepted -> pending is overwritten; inst_addr = 0x1c008000. A later br_flush while EXC is pending is ignored.
- btb_valid = 1, btb_taken = 1, btb_target = 0x1c000040 with inst_addr_ok = 0 -> the following cycle (btb_valid = 0) still presents 0x1c000040; after accept, 0x1c000044.
- idle_flush, ws_pc = 0x1c000020, has_int = 0 -> idle_lock = 1 and inst_req = 0 for N cycles. has_int = 1 -> lock clears; next inst_addr = 0x1c000024.
- ertn_flush with era = 0x1c000002 -> inst_addr = 0x1c000002 and inst_adef = 1. Separately, last_pc = 0xfffffffc in SEQ -> inst_addr = 0x00000000.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Pre-IF next-PC selection and icache request handshake: prioritises flush, branch,
// BTB and sequential sources, parks unaccepted redirects in a pending slot, owns idle lock.
module fetch_redirect_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_ready,
  input  logic        excp_flush,
  input  logic [31:0] excp_target,
  input  logic        ertn_flush,
  input  logic [31:0] era,
  input  logic        refetch_flush,
  input  logic        icacop_flush,
  input  logic        idle_flush,
  input  logic [31:0] ws_pc,
  input  logic        has_int,
  input  logic        br_flush,
  input  logic [31:0] br_target,
  input  logic        btb_valid,
  input  logic        btb_taken,
  input  logic [31:0] btb_target,
  input  logic        inst_addr_ok,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  output logic        inst_adef,
  output logic        redirect_kill,
  output logic        pend_valid,
  output logic        idle_lock
);

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [1:0]  CLS_BR   = 2'd1;
  localparam logic [1:0]  CLS_FL   = 2'd2;
  localparam logic [1:0]  CLS_EXC  = 2'd3;

  logic        r_pend_valid;
  logic [1:0]  r_pend_cls;
  logic [31:0] r_pend_target;
  logic        r_btb_hold;
  logic [31:0] r_btb_target;
  logic [31:0] r_last_pc;
  logic        r_idle_lock;

  logic        w_fl;
  logic        w_live;
  logic [1:0]  w_live_cls;
  logic [31:0] w_live_target;
  logic        w_live_wins;
  logic        w_btb_live;
  logic [31:0] w_nextpc;
  logic        w_req;
  logic        w_accept;

  assign w_fl   = ertn_flush | refetch_flush | icacop_flush | idle_flush;
  assign w_live = excp_flush | w_fl | br_flush;

  always_comb begin
    w_live_cls    = 2'd0;
    w_live_target = br_target;
    if (excp_flush) begin
      w_live_cls    = CLS_EXC;
      w_live_target = excp_target;
    end else if (w_fl) begin
      w_live_cls    = CLS_FL;
      w_live_target = ertn_flush ? era : (ws_pc + 32'd4);
    end else if (br_flush) begin
      w_live_cls    = CLS_BR;
      w_live_target = br_target;
    end
  end

  // A live event of lower class than the parked redirect loses to it and is dropped.
  assign w_live_wins = w_live && (!r_pend_valid || (w_live_cls >= r_pend_cls));
  assign w_btb_live  = btb_valid && btb_taken;

  always_comb begin
    w_nextpc = r_last_pc + 32'd4;
    if (w_live_wins)       w_nextpc = w_live_target;
    else if (r_pend_valid) w_nextpc = r_pend_target;
    else if (w_btb_live)   w_nextpc = btb_target;
    else if (r_btb_hold)   w_nextpc = r_btb_target;
  end

  assign w_req    = resetn && !r_idle_lock && !idle_flush &&
                    (r_pend_valid || w_live || fetch_ready);
  assign w_accept = w_req && inst_addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_pc    <= RESET_PC - 32'd4;
      r_pend_valid <= 1'b0;
      r_pend_cls   <= 2'd0;
      r_btb_hold   <= 1'b0;
      r_idle_lock  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_pc    <= w_nextpc;
        r_pend_valid <= 1'b0;
        r_pend_cls   <= 2'd0;
      end else if (w_live_wins) begin
        r_pend_valid <= 1'b1;
        r_pend_cls   <= w_live_cls;
      end
      if (w_accept || w_live)  r_btb_hold <= 1'b0;
      else if (btb_valid)      r_btb_hold <= btb_taken;
      if (has_int)             r_idle_lock <= 1'b0;
      else if (idle_flush)     r_idle_lock <= 1'b1;
    end
  end

  // Payload registers only matter while their valid bits are set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!w_accept && w_live_wins)            r_pend_target <= w_live_target;
    if (!w_accept && !w_live && btb_valid)   r_btb_target  <= btb_target;
  end

  assign inst_req      = w_req;
  assign inst_addr     = w_nextpc;
  assign inst_adef     = (w_nextpc[1:0] != 2'b00);
  assign redirect_kill = resetn && w_live;
  assign pend_valid    = r_pend_valid;
  assign idle_lock     = r_idle_lock;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Table-driven bench for fetch_redirect_ctrl with a queue of expected outputs per cycle.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_ready, excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
  logic        has_int, br_flush, btb_valid, btb_taken, inst_addr_ok;
  logic [31:0] excp_target, era, ws_pc, br_target, btb_target;
  logic        inst_req, inst_adef, redirect_kill, pend_valid, idle_lock;
  logic [31:0] inst_addr;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk(clk), .resetn(resetn), .fetch_ready(fetch_ready),
    .excp_flush(excp_flush), .excp_target(excp_target),
    .ertn_flush(ertn_flush), .era(era),
    .refetch_flush(refetch_flush), .icacop_flush(icacop_flush), .idle_flush(idle_flush),
    .ws_pc(ws_pc), .has_int(has_int),
    .br_flush(br_flush), .br_target(br_target),
    .btb_valid(btb_valid), .btb_taken(btb_taken), .btb_target(btb_target),
    .inst_addr_ok(inst_addr_ok),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_adef(inst_adef),
    .redirect_kill(redirect_kill), .pend_valid(pend_valid), .idle_lock(idle_lock)
  );

  // ev: 0 none, 1 br, 2 exc, 3 ertn, 4 idle, 5 refetch, 6 icacop
  typedef struct {
    bit          fr;
    bit          aok;
    int          ev;
    logic [31:0] tgt;
    bit          bv;
    bit          btk;
    logic [31:0] btt;
    bit          hi;
    bit          req;
    logic [31:0] addr;
    bit          kill;
    bit          pv;
    bit          il;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input bit fr, input bit aok, input int ev, input logic [31:0] tgt,
                     input bit bv, input bit btk, input logic [31:0] btt, input bit hi,
                     input bit req, input logic [31:0] addr, input bit kill,
                     input bit pv, input bit il);
    vec_t v;
    v.fr = fr; v.aok = aok; v.ev = ev; v.tgt = tgt; v.bv = bv; v.btk = btk; v.btt = btt;
    v.hi = hi; v.req = req; v.addr = addr; v.kill = kill; v.pv = pv; v.il = il;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0; refetch_flush = 1'b0;
    icacop_flush = 1'b0; idle_flush = 1'b0; has_int = 1'b0; br_flush = 1'b0;
    btb_valid = 1'b0; btb_taken = 1'b0; inst_addr_ok = 1'b0;
    excp_target = 32'h0; era = 32'h0; ws_pc = 32'h0; br_target = 32'h0; btb_target = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    idle_inputs();
    fetch_ready = v.fr; inst_addr_ok = v.aok; has_int = v.hi;
    btb_valid = v.bv; btb_taken = v.btk; btb_target = v.btt;
    case (v.ev)
      1: begin br_flush = 1'b1;      br_target   = v.tgt; end
      2: begin excp_flush = 1'b1;    excp_target = v.tgt; end
      3: begin ertn_flush = 1'b1;    era         = v.tgt; end
      4: begin idle_flush = 1'b1;    ws_pc       = v.tgt; end
      5: begin refetch_flush = 1'b1; ws_pc       = v.tgt; end
      6: begin icacop_flush = 1'b1;  ws_pc       = v.tgt; end
      default: ;
    endcase
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_front(input string tag, input bit chk_addr);
    vec_t e;
    logic [31:0] exp_adef;
    e = sb_q.pop_front();
    exp_adef = {31'd0, (e.addr[1:0] != 2'b00)};
    cmp({tag, ".req"},  {31'd0, inst_req},      {31'd0, e.req});
    if (chk_addr) begin
      cmp({tag, ".addr"}, inst_addr, e.addr);
      cmp({tag, ".adef"}, {31'd0, inst_adef}, exp_adef);
    end
    cmp({tag, ".kill"}, {31'd0, redirect_kill}, {31'd0, e.kill});
    cmp({tag, ".pend"}, {31'd0, pend_valid},    {31'd0, e.pv});
    cmp({tag, ".lock"}, {31'd0, idle_lock},     {31'd0, e.il});
  endtask

  task automatic step(input vec_t v, input string tag, input bit chk_addr);
    @(negedge clk);
    drive(v);
    sb_q.push_back(v);
    #1;
    check_front(tag, chk_addr);
  endtask

  vec_t h;

  initial begin
    idle_inputs();
    resetn = 1'b0;
    // Reset: outputs quiet even with a live event and fetch_ready present.
    h = '{fr:1, aok:1, ev:1, tgt:32'h1c000100, bv:0, btk:0, btt:0, hi:0,
          req:0, addr:32'h1c000100, kill:0, pv:0, il:0};
    step(h, "reset", 1'b0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;

    //   fr aok ev tgt            bv btk btt           hi  req addr          kill pv il
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000000, 0, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000004, 0, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000008, 0, 0, 0);
    add(1, 0, 1, 32'h1c000100,   0, 0, 32'h0,         0,  1, 32'h1c000100, 1, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000100, 0, 1, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000100, 0, 1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000100, 0, 1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000104, 0, 0, 0);
    add(1, 0, 1, 32'h1c000200,   0, 0, 32'h0,         0,  1, 32'h1c000200, 1, 0, 0);
    add(1, 0, 2, 32'h1c008000,   0, 0, 32'h0,         0,  1, 32'h1c008000, 1, 1, 0);
    add(1, 0, 1, 32'h1c000300,   0, 0, 32'h0,         0,  1, 32'h1c008000, 1, 1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c008000, 0, 1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c008004, 0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 1, 32'h1c000040,  0,  1, 32'h1c000040, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000040, 0, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000040, 0, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000044, 0, 0, 0);
    add(1, 1, 0, 32'h0,          1, 0, 32'h1c000900,  0,  1, 32'h1c000048, 0, 0, 0);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  0, 32'h1c00004c, 0, 0, 0);
    add(1, 1, 4, 32'h1c000020,   0, 0, 32'h0,         0,  0, 32'h1c000024, 1, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  0, 32'h1c000024, 0, 1, 1);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  0, 32'h1c000024, 0, 1, 1);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         1,  0, 32'h1c000024, 0, 1, 1);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000024, 0, 1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000028, 0, 0, 0);
    add(1, 1, 4, 32'h1c000060,   0, 0, 32'h0,         1,  0, 32'h1c000064, 1, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000064, 0, 1, 0);
    add(1, 1, 3, 32'h1c000002,   0, 0, 32'h0,         0,  1, 32'h1c000002, 1, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000006, 0, 0, 0);
    add(1, 1, 1, 32'hfffffffc,   0, 0, 32'h0,         0,  1, 32'hfffffffc, 1, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h00000000, 0, 0, 0);
    add(1, 1, 5, 32'h1c000010,   0, 0, 32'h0,         0,  1, 32'h1c000014, 1, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000018, 0, 0, 0);
    add(1, 0, 1, 32'h1c000500,   0, 0, 32'h0,         0,  1, 32'h1c000500, 1, 0, 0);
    add(1, 0, 6, 32'h1c000700,   0, 0, 32'h0,         0,  1, 32'h1c000704, 1, 1, 0);
    add(1, 1, 1, 32'h1c000800,   0, 0, 32'h0,         0,  1, 32'h1c000704, 1, 1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h1c000708, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i), 1'b1);

    // Simultaneous EXC, ertn and BR: exception target wins and is parked.
    @(negedge clk);
    idle_inputs();
    fetch_ready = 1'b1;
    excp_flush = 1'b1; excp_target = 32'h1c00a000;
    ertn_flush = 1'b1; era = 32'h1c00c000;
    br_flush = 1'b1;   br_target = 32'h1c00b000;
    h = '{fr:1, aok:0, ev:2, tgt:32'h1c00a000, bv:0, btk:0, btt:0, hi:0,
          req:1, addr:32'h1c00a000, kill:1, pv:0, il:0};
    sb_q.push_back(h);
    #1;
    check_front("prio", 1'b1);
    h = '{fr:1, aok:0, ev:0, tgt:0, bv:0, btk:0, btt:0, hi:0,
          req:1, addr:32'h1c00a000, kill:0, pv:1, il:0};
    step(h, "prio_pend", 1'b1);

    // Reset asserted mid-pending discards the parked redirect.
    #2;
    resetn = 1'b0;
    #1;
    cmp("rst_pend", {31'd0, pend_valid}, 32'd0);
    cmp("rst_req",  {31'd0, inst_req},   32'd0);
    @(negedge clk);
    resetn = 1'b1;
    h = '{fr:1, aok:1, ev:0, tgt:0, bv:0, btk:0, btt:0, hi:0,
          req:1, addr:32'h1c000000, kill:0, pv:0, il:0};
    step(h, "post_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
